multicycle_ctrl_fsm: RTL and testbench

// - Multi-cycle sequencer for the RV32I core.
// - Replaces the single-cycle decode with a state machine that time-shares one ALU and one unified

---
 rtl/rv_ctrl_pkg.sv | 85 ++++++++
 rtl/alu_decoder.sv | 45 ++++
 rtl/multicycle_ctrl_fsm.sv | 276 +++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_ctrl_pkg
// Description : Shared types and encodings for the RV32I multi-cycle control
//               path: sequencer states, opcode values, funct3 values, and the
//               select/control codes driven onto the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    // Sequencer states (explicit 4-bit encoding).
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALWB    = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    // Operation class handed to the ALU decoder by the sequencer.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_RTYPE = 2'd2,
        ALUOP_ITYPE = 2'd3
    } alu_op_t;

    // Opcodes
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;

    // funct3 values
    localparam logic [2:0] c_f3_add = 3'b000;
    localparam logic [2:0] c_f3_sll = 3'b001;
    localparam logic [2:0] c_f3_xor = 3'b100;
    localparam logic [2:0] c_f3_or  = 3'b110;
    localparam logic [2:0] c_f3_and = 3'b111;
    localparam logic [2:0] c_f3_beq = 3'b000;
    localparam logic [2:0] c_f3_bne = 3'b001;

    // ALU control codes
    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_xor = 3'b100;
    localparam logic [2:0] c_alu_sll = 3'b101;

    // Immediate formats
    localparam logic [1:0] c_imm_i = 2'b00;
    localparam logic [1:0] c_imm_s = 2'b01;
    localparam logic [1:0] c_imm_b = 2'b10;
    localparam logic [1:0] c_imm_j = 2'b11;

    // Result mux selects
    localparam logic [1:0] c_res_aluout  = 2'b00;
    localparam logic [1:0] c_res_memdata = 2'b01;
    localparam logic [1:0] c_res_alu     = 2'b10;

    // ALU operand A selects
    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rs1   = 2'b10;

    // ALU operand B selects
    localparam logic [1:0] c_srcb_rs2  = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

endpackage : rv_ctrl_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational ALU control decode. The sequencer supplies an
//               operation class; for register and immediate arithmetic the
//               operation is taken from funct3 (and funct7[5] for sub).
// Ports       : alu_op_i    in  2  operation class (alu_op_t)
//               funct3_i    in  3  instruction funct3
//               funct7_5_i  in  1  instruction bit 30
//               alu_ctrl_o  out 3  ALU control code
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [2:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = c_alu_add;
        case (alu_op_i)
            ALUOP_ADD: alu_ctrl_o = c_alu_add;
            ALUOP_SUB: alu_ctrl_o = c_alu_sub;
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (funct3_i)
                    // Bit 30 selects sub only for register form; in the
                    // immediate form it is part of the immediate.
                    c_f3_add: alu_ctrl_o = (alu_op_i == ALUOP_RTYPE && funct7_5_i)
                                           ? c_alu_sub : c_alu_add;
                    c_f3_and: alu_ctrl_o = c_alu_and;
                    c_f3_or:  alu_ctrl_o = c_alu_or;
                    c_f3_xor: alu_ctrl_o = c_alu_xor;
                    c_f3_sll: alu_ctrl_o = c_alu_sll;
                    default:  alu_ctrl_o = c_alu_add;
                endcase
            end
            default: alu_ctrl_o = c_alu_add;
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Multi-cycle sequencer for an RV32I core. Time-shares one ALU
//               and one unified memory port over fetch, decode, execute,
//               memory and writeback steps; traps on illegal instructions.
// Ports       : clk_i        in   clock, rising edge
//               rst_ni       in   asynchronous active-low reset
//               instr_i      in   instruction register contents
//               Zero_i       in   ALU zero flag
//               mem_ready_i  in   memory completes current access
//               PCWrite_o, IRWrite_o, AdrSrc_o, MemRead_o, MemWrite_o,
//               RegWrite_o   out  datapath enables/selects
//               ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ResultSrc_o  out  mux selects
//               ALUctrl_o    out  ALU operation
//               retire_o     out  instruction completes this cycle
//               trap_o       out  illegal instruction seen (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 3,
    parameter int IMM_WIDTH     = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [DATA_WIDTH-1:0]    instr_i,
    input  logic                     Zero_i,
    input  logic                     mem_ready_i,
    output logic                     PCWrite_o,
    output logic                     IRWrite_o,
    output logic                     AdrSrc_o,
    output logic                     MemRead_o,
    output logic                     MemWrite_o,
    output logic                     RegWrite_o,
    output logic [IMM_WIDTH-1:0]     ALUSrcA_o,
    output logic [IMM_WIDTH-1:0]     ALUSrcB_o,
    output logic [CONTROL_WIDTH-1:0] ALUctrl_o,
    output logic [IMM_WIDTH-1:0]     ImmSrc_o,
    output logic [IMM_WIDTH-1:0]     ResultSrc_o,
    output logic                     retire_o,
    output logic                     trap_o
);

    state_t     r_state;
    state_t     w_next_state;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_5;

    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_adr_src;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_reg_write;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [1:0] w_imm_src;
    logic [1:0] w_result_src;
    logic       w_retire;
    logic       w_trap;
    alu_op_t    w_alu_op;
    logic [2:0] w_alu_ctrl;

    // Instruction bits not involved in control decode.
    logic       w_unused_instr;

    assign w_opcode       = instr_i[6:0];
    assign w_funct3       = instr_i[14:12];
    assign w_funct7_5     = instr_i[30];
    assign w_unused_instr = ^{instr_i[DATA_WIDTH-1:31], instr_i[29:15], instr_i[11:7]};

    alu_decoder u_alu_decoder (
        .alu_op_i   (w_alu_op),
        .funct3_i   (w_funct3),
        .funct7_5_i (w_funct7_5),
        .alu_ctrl_o (w_alu_ctrl)
    );

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_src_a      = c_srca_pc;
        w_src_b      = c_srcb_rs2;
        w_imm_src    = c_imm_i;
        w_result_src = c_res_aluout;
        w_retire     = 1'b0;
        w_trap       = 1'b0;
        w_alu_op     = ALUOP_ADD;

        case (r_state)
            S_FETCH: begin
                // PC + 4 is computed alongside the fetch and written straight
                // from the ALU result when the instruction arrives.
                w_mem_read = 1'b1;
                w_src_a    = c_srca_pc;
                w_src_b    = c_srcb_four;
                if (mem_ready_i) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_result_src = c_res_alu;
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                // Branch/jump target speculatively computed into ALUOut.
                w_src_a   = c_srca_oldpc;
                w_src_b   = c_srcb_imm;
                w_imm_src = c_imm_b;
                case (w_opcode)
                    c_op_load,
                    c_op_store:  w_next_state = S_MEMADR;
                    c_op_rtype:  w_next_state = S_EXECR;
                    c_op_itype:  w_next_state = S_EXECI;
                    c_op_branch: w_next_state = S_BRANCH;
                    c_op_jal:    w_next_state = S_JAL;
                    c_op_jalr:   w_next_state = S_JALR;
                    default:     w_next_state = S_TRAP;
                endcase
            end

            S_MEMADR: begin
                w_src_a   = c_srca_rs1;
                w_src_b   = c_srcb_imm;
                w_imm_src = (w_opcode == c_op_store) ? c_imm_s : c_imm_i;
                w_next_state = (w_opcode == c_op_store) ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                w_adr_src  = 1'b1;
                w_mem_read = 1'b1;
                if (mem_ready_i) begin
                    w_next_state = S_MEMWB;
                end
            end

            S_MEMWB: begin
                w_result_src = c_res_memdata;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end

            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready_i) begin
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end

            S_EXECR: begin
                w_src_a      = c_srca_rs1;
                w_src_b      = c_srcb_rs2;
                w_alu_op     = ALUOP_RTYPE;
                w_next_state = S_ALUWB;
            end

            S_EXECI: begin
                w_src_a      = c_srca_rs1;
                w_src_b      = c_srcb_imm;
                w_imm_src    = c_imm_i;
                w_alu_op     = ALUOP_ITYPE;
                w_next_state = S_ALUWB;
            end

            S_ALUWB: begin
                w_result_src = c_res_aluout;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end

            S_BRANCH: begin
                // Compare rs1/rs2; the target already sits in ALUOut.
                w_src_a      = c_srca_rs1;
                w_src_b      = c_srcb_rs2;
                w_alu_op     = ALUOP_SUB;
                w_result_src = c_res_aluout;
                case (w_funct3)
                    c_f3_beq: begin
                        w_pc_write   = Zero_i;
                        w_retire     = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    c_f3_bne: begin
                        w_pc_write   = ~Zero_i;
                        w_retire     = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    default: w_next_state = S_TRAP;
                endcase
            end

            S_JAL: begin
                // PC takes the DECODE target from ALUOut while OldPC + 4 is
                // formed for the link register.
                w_src_a      = c_srca_oldpc;
                w_src_b      = c_srcb_four;
                w_pc_write   = 1'b1;
                w_result_src = c_res_aluout;
                w_next_state = S_ALUWB;
            end

            S_JALR: begin
                w_src_a      = c_srca_rs1;
                w_src_b      = c_srcb_imm;
                w_imm_src    = c_imm_i;
                w_result_src = c_res_alu;
                w_pc_write   = 1'b1;
                w_next_state = S_JALWB;
            end

            S_JALWB: begin
                w_src_a      = c_srca_oldpc;
                w_src_b      = c_srcb_four;
                w_result_src = c_res_alu;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end

            S_TRAP: begin
                w_trap       = 1'b1;
                w_next_state = S_TRAP;
            end

            default: w_next_state = S_TRAP;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs are forced low while reset is held, so an interrupted memory
    // request disappears in the same cycle reset is asserted.
    // ------------------------------------------------------------------------
    assign PCWrite_o   = rst_ni & w_pc_write;
    assign IRWrite_o   = rst_ni & w_ir_write;
    assign AdrSrc_o    = rst_ni & w_adr_src;
    assign MemRead_o   = rst_ni & w_mem_read;
    assign MemWrite_o  = rst_ni & w_mem_write;
    assign RegWrite_o  = rst_ni & w_reg_write;
    assign retire_o    = rst_ni & w_retire;
    assign trap_o      = rst_ni & w_trap;
    assign ALUSrcA_o   = IMM_WIDTH'(w_src_a & {2{rst_ni}});
    assign ALUSrcB_o   = IMM_WIDTH'(w_src_b & {2{rst_ni}});
    assign ImmSrc_o    = IMM_WIDTH'(w_imm_src & {2{rst_ni}});
    assign ResultSrc_o = IMM_WIDTH'(w_result_src & {2{rst_ni}});
    assign ALUctrl_o   = CONTROL_WIDTH'(w_alu_ctrl & {3{rst_ni}});

endmodule : multicycle_ctrl_fsm
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl_fsm
// Description : Scoreboard bench for multicycle_ctrl_fsm. Stimulus walks each
//               instruction through its expected step sequence, pushing the
//               expected output vector for every cycle; a monitor pops and
//               compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] instr_i;
    logic        Zero_i;
    logic        mem_ready_i;
    logic        PCWrite_o, IRWrite_o, AdrSrc_o, MemRead_o, MemWrite_o, RegWrite_o;
    logic [1:0]  ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ResultSrc_o;
    logic [2:0]  ALUctrl_o;
    logic        retire_o, trap_o;

    multicycle_ctrl_fsm dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .instr_i     (instr_i),
        .Zero_i      (Zero_i),
        .mem_ready_i (mem_ready_i),
        .PCWrite_o   (PCWrite_o),
        .IRWrite_o   (IRWrite_o),
        .AdrSrc_o    (AdrSrc_o),
        .MemRead_o   (MemRead_o),
        .MemWrite_o  (MemWrite_o),
        .RegWrite_o  (RegWrite_o),
        .ALUSrcA_o   (ALUSrcA_o),
        .ALUSrcB_o   (ALUSrcB_o),
        .ALUctrl_o   (ALUctrl_o),
        .ImmSrc_o    (ImmSrc_o),
        .ResultSrc_o (ResultSrc_o),
        .retire_o    (retire_o),
        .trap_o      (trap_o)
    );

    always #5 clk_i = ~clk_i;

    // pcw irw adr mrd mwr rw | srcA srcB | alu | imm res | retire trap
    typedef struct packed {
        logic       pcw, irw, adr, mrd, mwr, rw;
        logic [1:0] sa, sb;
        logic [2:0] alu;
        logic [1:0] imm, res;
        logic       ret, trp;
    } outv_t;

    typedef struct {
        outv_t v;
        string tag;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    outv_t act;

    assign act = {PCWrite_o, IRWrite_o, AdrSrc_o, MemRead_o, MemWrite_o, RegWrite_o,
                  ALUSrcA_o, ALUSrcB_o, ALUctrl_o, ImmSrc_o, ResultSrc_o, retire_o, trap_o};

    logic [2:0] arith_f3 [5] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b001};

    // ---------------- reference model: per-step expected outputs ------------
    function automatic outv_t mk(input logic pcw, irw, adr, mrd, mwr, rw,
                                 input logic [1:0] sa, sb, input logic [2:0] alu,
                                 input logic [1:0] imm, res, input logic ret, trp);
        outv_t o;
        o = {pcw, irw, adr, mrd, mwr, rw, sa, sb, alu, imm, res, ret, trp};
        return o;
    endfunction

    function automatic outv_t e_zero();
        return mk(0,0,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,2'b00, 0,0);
    endfunction
    function automatic outv_t e_fetch(input logic rdy);
        return mk(rdy,rdy,0,1,0,0, 2'b00,2'b10,3'b000,2'b00, rdy ? 2'b10 : 2'b00, 0,0);
    endfunction
    function automatic outv_t e_decode();
        return mk(0,0,0,0,0,0, 2'b01,2'b01,3'b000,2'b10,2'b00, 0,0);
    endfunction
    function automatic outv_t e_memadr(input logic is_sw);
        return mk(0,0,0,0,0,0, 2'b10,2'b01,3'b000, is_sw ? 2'b01 : 2'b00, 2'b00, 0,0);
    endfunction
    function automatic outv_t e_memread();
        return mk(0,0,1,1,0,0, 2'b00,2'b00,3'b000,2'b00,2'b00, 0,0);
    endfunction
    function automatic outv_t e_memwb();
        return mk(0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b00,2'b01, 1,0);
    endfunction
    function automatic outv_t e_memwrite(input logic rdy);
        return mk(0,0,1,0,1,0, 2'b00,2'b00,3'b000,2'b00,2'b00, rdy,0);
    endfunction
    function automatic outv_t e_execr(input logic [2:0] alu);
        return mk(0,0,0,0,0,0, 2'b10,2'b00,alu,2'b00,2'b00, 0,0);
    endfunction
    function automatic outv_t e_execi(input logic [2:0] alu);
        return mk(0,0,0,0,0,0, 2'b10,2'b01,alu,2'b00,2'b00, 0,0);
    endfunction
    function automatic outv_t e_aluwb();
        return mk(0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b00,2'b00, 1,0);
    endfunction
    function automatic outv_t e_branch(input logic pcw, input logic ret);
        return mk(pcw,0,0,0,0,0, 2'b10,2'b00,3'b001,2'b00,2'b00, ret,0);
    endfunction
    function automatic outv_t e_jal();
        return mk(1,0,0,0,0,0, 2'b01,2'b10,3'b000,2'b00,2'b00, 0,0);
    endfunction
    function automatic outv_t e_jalr();
        return mk(1,0,0,0,0,0, 2'b10,2'b01,3'b000,2'b00,2'b10, 0,0);
    endfunction
    function automatic outv_t e_jalwb();
        return mk(0,0,0,0,0,1, 2'b01,2'b10,3'b000,2'b00,2'b10, 1,0);
    endfunction
    function automatic outv_t e_trap();
        return mk(0,0,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,2'b00, 0,1);
    endfunction

    // ALU operation implied by funct3 (and bit 30 for register sub).
    function automatic logic [2:0] ref_alu(input logic [31:0] ins, input logic is_r);
        case (ins[14:12])
            3'b000:  return (is_r && ins[30]) ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b100:  return 3'b100;
            3'b001:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic rb();
        return ($urandom & 1) != 0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0]  f3;
        int          k;
        r  = $urandom;
        k  = $urandom_range(0, 6);
        f3 = arith_f3[$urandom_range(0, 4)];
        case (k)
            0: begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
            1: begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
            2: begin
                r[6:0] = 7'b0110011; r[14:12] = f3;
                r[31:25] = (f3 == 3'b000 && rb()) ? 7'b0100000 : 7'b0000000;
            end
            3: begin
                r[6:0] = 7'b0010011; r[14:12] = f3;
                if (f3 == 3'b001) r[31:25] = 7'b0000000;
            end
            4: begin r[6:0] = 7'b1100011; r[14:12] = rb() ? 3'b001 : 3'b000; end
            5: r[6:0] = 7'b1101111;
            default: begin r[6:0] = 7'b1100111; r[14:12] = 3'b000; end
        endcase
        return r;
    endfunction

    // ---------------- stimulus helpers --------------------------------------
    task automatic step(input outv_t v, input string tag, input logic rdy, input logic z);
        exp_t e;
        mem_ready_i = rdy;
        Zero_i      = z;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_pulse();
        rst_ni = 1'b0;
        step(e_zero(), "reset_outputs", rb(), rb());
        rst_ni = 1'b1;
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++) step(e_trap(), "trap_hold", rb(), rb());
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z);
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        instr_i = $urandom;  // IR still holds the previous word during fetch
        for (int i = 0; i < fw; i++) step(e_fetch(1'b0), "fetch_wait", 1'b0, rb());
        step(e_fetch(1'b1), "fetch", 1'b1, rb());
        instr_i = ins;
        step(e_decode(), "decode", rb(), rb());
        case (op)
            7'b0000011: begin
                step(e_memadr(1'b0), "memadr_lw", rb(), rb());
                for (int i = 0; i < mw; i++) step(e_memread(), "memread_wait", 1'b0, rb());
                step(e_memread(), "memread", 1'b1, rb());
                step(e_memwb(), "memwb", rb(), rb());
            end
            7'b0100011: begin
                step(e_memadr(1'b1), "memadr_sw", rb(), rb());
                for (int i = 0; i < mw; i++) step(e_memwrite(1'b0), "memwrite_wait", 1'b0, rb());
                step(e_memwrite(1'b1), "memwrite", 1'b1, rb());
            end
            7'b0110011: begin
                step(e_execr(ref_alu(ins, 1'b1)), "execr", rb(), rb());
                step(e_aluwb(), "aluwb", rb(), rb());
            end
            7'b0010011: begin
                step(e_execi(ref_alu(ins, 1'b0)), "execi", rb(), rb());
                step(e_aluwb(), "aluwb", rb(), rb());
            end
            7'b1100011: begin
                if (f3 == 3'b000)      step(e_branch(z, 1'b1), "branch_beq", rb(), z);
                else if (f3 == 3'b001) step(e_branch(!z, 1'b1), "branch_bne", rb(), z);
                else begin
                    step(e_branch(1'b0, 1'b0), "branch_bad_funct3", rb(), z);
                    trap_hold(4);
                    reset_pulse();
                end
            end
            7'b1101111: begin
                step(e_jal(), "jal", rb(), rb());
                step(e_aluwb(), "jal_wb", rb(), rb());
            end
            7'b1100111: begin
                step(e_jalr(), "jalr", rb(), rb());
                step(e_jalwb(), "jalwb", rb(), rb());
            end
            default: begin
                trap_hold(20);
                reset_pulse();
            end
        endcase
    endtask

    // ---------------- monitor -----------------------------------------------
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s @%0t actual=%05h required=%05h", e.tag, $time, act, e.v);
            end
            checks++;
            if (MemRead_o && MemWrite_o) begin
                errors++;
                $display("FAIL rd_wr_exclusive @%0t actual=11 required=not both", $time);
            end
        end
    end

    // ---------------- main sequence -----------------------------------------
    initial begin
        rst_ni      = 1'b0;
        instr_i     = 32'h0;
        Zero_i      = 1'b0;
        mem_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 3; i++) step(e_zero(), "reset_init", rb(), rb());
        rst_ni = 1'b1;

        run_instr(32'h002081B3, 0, 0, 1'b0);   // add x3,x1,x2
        run_instr(32'h0000A103, 0, 2, 1'b0);   // lw, two memory wait cycles
        run_instr(32'h00208463, 0, 0, 1'b1);   // beq, taken
        run_instr(32'h00209463, 0, 0, 1'b1);   // bne, not taken
        run_instr(32'h00208463, 1, 0, 1'b0);   // beq, not taken
        run_instr(32'h00209463, 0, 0, 1'b0);   // bne, taken
        run_instr(32'h008000EF, 0, 0, 1'b0);   // jal
        run_instr(32'h0020A223, 0, 1, 1'b0);   // sw, one wait
        run_instr(32'h000080E7, 0, 0, 1'b0);   // jalr
        run_instr(32'h4020C1B3, 2, 0, 1'b0);   // xor with bit 30 set, fetch waits
        run_instr(32'h40008093, 0, 0, 1'b0);   // addi with bit 30 set in imm

        // Reset while a load is waiting on memory.
        instr_i = $urandom;
        step(e_fetch(1'b1), "fetch", 1'b1, rb());
        instr_i = 32'h0000A103;
        step(e_decode(), "decode", rb(), rb());
        step(e_memadr(1'b0), "memadr_lw", rb(), rb());
        step(e_memread(), "memread_wait", 1'b0, rb());
        reset_pulse();
        run_instr(32'h002081B3, 0, 0, 1'b0);

        run_instr(32'h0000007F, 0, 0, 1'b0);   // illegal opcode -> trap, then reset
        run_instr(32'h0020A463, 0, 0, 1'b1);   // branch funct3 010 -> trap, then reset
        run_instr(32'h002081B3, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++)
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), rb());

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_multicycle_ctrl_fsm
`default_nettype wire
